// File: rtl/ppu_vram_responder.sv
// ppu_vram_responder: board-side responder for the PPU multiplexed video-memory bus.
// Demultiplexes ALE/AD, decodes CHR and nametable space and serves reads and
// writes from internal RAM. All bus pins are asynchronous to CLK.
module ppu_vram_responder #(
   parameter bit CHR_WRITABLE = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ALE,
   input  logic        RD,
   input  logic        WR,
   input  logic [7:0]  ad_in,
   input  logic [5:0]  a_hi,
   input  logic        mirror_vertical,
   input  logic        error_clear,
   output logic [7:0]  ad_out,
   output logic        ad_oe,
   output logic        protocol_error,
   output logic [15:0] read_count,
   output logic [15:0] write_count
);

   typedef enum logic [2:0] {IDLE, ARMED, RD_WAIT, RD_DRIVE, WR_HOLD} state_t;

   // First address of the unmapped palette window.
   localparam logic [13:0] UNMAPPED_BASE = 14'h3F00;

   // Strobe chains: bit 0 = s1, bit 1 = s2, bit 2 = s3 (edge history).
   logic [2:0]  ale_sync, rd_sync, wr_sync;
   logic [7:0]  ad_s1, ad_s2;
   logic [5:0]  a_hi_s1, a_hi_s2;

   logic        ale_rise, ale_fall, rd_fall, wr_fall, rd_high, wr_high, overlap;

   state_t      state, state_next;
   logic [13:0] addr;
   logic        mirror_q;
   logic [7:0]  wdata;
   logic [7:0]  ram_q;

   logic        mapped, is_chr, writable;
   logic [12:0] chr_idx;
   logic [10:0] nt_idx;
   logic        rd_issue, rd_done, wr_done, err_set, commit;

   logic [7:0]  chr_mem [0:8191];
   logic [7:0]  nt_mem  [0:2047];

   // Two-flop synchronisers for every bus pin, plus a history flop on the strobes.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ale_sync <= 3'b000;
         rd_sync  <= 3'b111;
         wr_sync  <= 3'b111;
         ad_s1    <= '0;
         ad_s2    <= '0;
         a_hi_s1  <= '0;
         a_hi_s2  <= '0;
      end else begin
         ale_sync <= {ale_sync[1:0], ALE};
         rd_sync  <= {rd_sync[1:0], RD};
         wr_sync  <= {wr_sync[1:0], WR};
         ad_s1    <= ad_in;
         ad_s2    <= ad_s1;
         a_hi_s1  <= a_hi;
         a_hi_s2  <= a_hi_s1;
      end
   end

   assign ale_rise = ale_sync[1] & ~ale_sync[2];
   assign ale_fall = ~ale_sync[1] & ale_sync[2];
   assign rd_fall  = ~rd_sync[1] & rd_sync[2];
   assign wr_fall  = ~wr_sync[1] & wr_sync[2];
   // Access completion keys off the synced level: identical to the rise for
   // legal pulses, and cannot strand the FSM if a short pulse loses its edge.
   assign rd_high  = rd_sync[1];
   assign wr_high  = wr_sync[1];
   assign overlap  = ~rd_sync[1] & ~wr_sync[1];

   // Address decode of the latched address.
   assign mapped   = (addr < UNMAPPED_BASE);
   assign is_chr   = ~addr[13];
   assign writable = ~is_chr | CHR_WRITABLE;
   assign chr_idx  = addr[12:0];
   assign nt_idx   = mirror_q ? {addr[10], addr[9:0]} : {addr[11], addr[9:0]};
   assign commit   = wr_done & mapped & writable;

   // Next-state and per-cycle strobes of the access FSM.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      rd_issue   = 1'b0;
      rd_done    = 1'b0;
      wr_done    = 1'b0;
      err_set    = 1'b0;
      if (overlap) begin
         err_set    = 1'b1;
         state_next = IDLE;
      end else if (ale_rise) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (ale_fall) begin
                  state_next = ARMED;
               end else if (rd_fall || wr_fall) begin
                  err_set = 1'b1;
               end
            end
            ARMED: begin
               if (rd_fall) begin
                  state_next = RD_WAIT;
                  rd_issue   = 1'b1;
               end else if (wr_fall) begin
                  state_next = WR_HOLD;
               end
            end
            RD_WAIT: state_next = RD_DRIVE;
            RD_DRIVE: begin
               if (rd_high) begin
                  state_next = ARMED;
                  rd_done    = 1'b1;
               end
            end
            WR_HOLD: begin
               if (wr_high) begin
                  state_next = ARMED;
                  wr_done    = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Address/mirror latch, write-data capture and read-data drive registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         addr     <= '0;
         mirror_q <= 1'b0;
         wdata    <= '0;
         ad_out   <= '0;
         ad_oe    <= 1'b0;
      end else begin
         // Tracking while ALE is high leaves the value of the last ALE-high cycle.
         if (ale_sync[1]) begin
            addr <= {a_hi_s2, ad_s2};
         end
         if (ale_fall) begin
            mirror_q <= mirror_vertical;
         end
         if (state == WR_HOLD) begin
            wdata <= ad_s2;
         end
         if (state == RD_WAIT && state_next == RD_DRIVE && mapped) begin
            ad_out <= ram_q;
         end
         ad_oe <= (state_next == RD_DRIVE) && mapped;
      end
   end

   // Sticky error flag and transaction counters; a set beats a same-cycle clear.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         protocol_error <= 1'b0;
         read_count     <= '0;
         write_count    <= '0;
      end else begin
         if (err_set) begin
            protocol_error <= 1'b1;
         end else if (error_clear) begin
            protocol_error <= 1'b0;
         end
         if (rd_done && mapped) begin
            read_count <= read_count + 16'd1;
         end
         if (commit) begin
            write_count <= write_count + 16'd1;
         end
      end
   end

   // CHR and nametable RAM: write on commit, registered read on read issue.
   // NOTE: RAM arrays have no reset so they map onto block RAM and survive RST.
   always_ff @(posedge CLK) begin
      if (commit) begin
         if (is_chr) begin
            chr_mem[chr_idx] <= wdata;
         end else begin
            nt_mem[nt_idx] <= wdata;
         end
      end
      if (rd_issue) begin
         ram_q <= is_chr ? chr_mem[chr_idx] : nt_mem[nt_idx];
      end
   end

endmodule

// File: tb/tb_ppu_vram_responder.sv
// tb_ppu_vram_responder: directed bench for ppu_vram_responder. A writable-CHR
// and a read-only-CHR instance share one bus and are checked side by side.
module tb_ppu_vram_responder;

   logic        CLK, RST, ALE, RD, WR, mirror_vertical, error_clear;
   logic [7:0]  ad_in;
   logic [5:0]  a_hi;
   logic [7:0]  ad_out, ro_ad_out;
   logic        ad_oe, ro_ad_oe, protocol_error, ro_protocol_error;
   logic [15:0] read_count, write_count, ro_read_count, ro_write_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        wr;
      logic [13:0] addr;
      logic        mv;
      logic [7:0]  data;     // write data, or expected ad_out for a read
      logic        exp_oe;
      logic [15:0] rc;
      logic [15:0] wc;
      logic [15:0] wc_ro;
   } vec_t;

   ppu_vram_responder #(.CHR_WRITABLE(1'b1)) dut (
      .CLK(CLK), .RST(RST), .ALE(ALE), .RD(RD), .WR(WR),
      .ad_in(ad_in), .a_hi(a_hi), .mirror_vertical(mirror_vertical),
      .error_clear(error_clear), .ad_out(ad_out), .ad_oe(ad_oe),
      .protocol_error(protocol_error), .read_count(read_count),
      .write_count(write_count)
   );

   ppu_vram_responder #(.CHR_WRITABLE(1'b0)) dut_ro (
      .CLK(CLK), .RST(RST), .ALE(ALE), .RD(RD), .WR(WR),
      .ad_in(ad_in), .a_hi(a_hi), .mirror_vertical(mirror_vertical),
      .error_clear(error_clear), .ad_out(ro_ad_out), .ad_oe(ro_ad_oe),
      .protocol_error(ro_protocol_error), .read_count(ro_read_count),
      .write_count(ro_write_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Watchdog so the run always ends.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: time %0t reached, required finish before 1000000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance n edges and settle 1 time unit past the last one.
   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // NOTE: bus pins are driven with blocking assignments just after an edge.
   task automatic bus_latch(input logic [13:0] addr, input logic mv);
      ad_in           = addr[7:0];
      a_hi            = addr[13:8];
      mirror_vertical = mv;
      ALE             = 1'b1;
      cycles(4);
      ALE = 1'b0;
      cycles(4);
   endtask

   task automatic bus_write(input logic [7:0] data);
      ad_in = data;
      cycles(1);
      WR = 1'b0;
      cycles(5);
      WR = 1'b1;
      cycles(4);
   endtask

   // Six-clock RD pulse with drive-window checks on both instances.
   task automatic bus_read(input string tag, input logic exp_oe, input logic [7:0] exp_data,
                           input bit chk_dut, input bit chk_ro, output logic [7:0] ro_data);
      RD = 1'b0;
      cycles(3);
      check({tag, " oe before 3rd edge"}, 16'(ad_oe), 16'h0);
      cycles(1);
      check({tag, " oe after 3rd edge"}, 16'(ad_oe), 16'(exp_oe));
      check({tag, " ro oe after 3rd edge"}, 16'(ro_ad_oe), 16'(exp_oe));
      cycles(2);
      if (chk_dut) check({tag, " ad_out"}, 16'(ad_out), 16'(exp_data));
      if (chk_ro) check({tag, " ro ad_out"}, 16'(ro_ad_out), 16'(exp_data));
      ro_data = ro_ad_out;
      RD = 1'b1;
      cycles(2);
      check({tag, " oe 1 edge after rise"}, 16'(ad_oe), 16'(exp_oe));
      cycles(1);
      check({tag, " oe 2 edges after rise"}, 16'(ad_oe), 16'h0);
      cycles(1);
   endtask

   initial begin
      vec_t        vec [20];
      logic [7:0]  ro_tmp, ro_base;
      logic [15:0] exp_rc, exp_wc, exp_wc_ro;

      //         wr    addr      mv    data   oe    rc      wc      wc_ro
      vec[0]  = '{1'b1, 14'h2405, 1'b1, 8'hA5, 1'b0, 16'd0,  16'd1, 16'd1};
      vec[1]  = '{1'b0, 14'h2405, 1'b1, 8'hA5, 1'b1, 16'd1,  16'd1, 16'd1};
      vec[2]  = '{1'b0, 14'h2C05, 1'b0, 8'hA5, 1'b1, 16'd2,  16'd1, 16'd1};
      vec[3]  = '{1'b1, 14'h1ABC, 1'b1, 8'h3C, 1'b0, 16'd2,  16'd2, 16'd1};
      vec[4]  = '{1'b0, 14'h1ABC, 1'b1, 8'h3C, 1'b1, 16'd3,  16'd2, 16'd1};
      vec[5]  = '{1'b1, 14'h3123, 1'b1, 8'h77, 1'b0, 16'd3,  16'd3, 16'd2};
      vec[6]  = '{1'b0, 14'h2123, 1'b1, 8'h77, 1'b1, 16'd4,  16'd3, 16'd2};
      vec[7]  = '{1'b0, 14'h3F10, 1'b1, 8'h77, 1'b0, 16'd4,  16'd3, 16'd2};
      vec[8]  = '{1'b1, 14'h3F10, 1'b1, 8'h11, 1'b0, 16'd4,  16'd3, 16'd2};
      vec[9]  = '{1'b0, 14'h2123, 1'b0, 8'h77, 1'b1, 16'd5,  16'd3, 16'd2};
      vec[10] = '{1'b1, 14'h2800, 1'b1, 8'h5A, 1'b0, 16'd5,  16'd4, 16'd3};
      vec[11] = '{1'b0, 14'h2000, 1'b0, 8'h5A, 1'b1, 16'd6,  16'd4, 16'd3};
      vec[12] = '{1'b0, 14'h2400, 1'b0, 8'h5A, 1'b1, 16'd7,  16'd4, 16'd3};
      vec[13] = '{1'b1, 14'h0000, 1'b1, 8'hC3, 1'b0, 16'd7,  16'd5, 16'd3};
      vec[14] = '{1'b0, 14'h0000, 1'b1, 8'hC3, 1'b1, 16'd8,  16'd5, 16'd3};
      vec[15] = '{1'b1, 14'h1FFF, 1'b1, 8'hE1, 1'b0, 16'd8,  16'd6, 16'd3};
      vec[16] = '{1'b0, 14'h1FFF, 1'b1, 8'hE1, 1'b1, 16'd9,  16'd6, 16'd3};
      vec[17] = '{1'b1, 14'h3EFF, 1'b1, 8'h9D, 1'b0, 16'd9,  16'd7, 16'd4};
      vec[18] = '{1'b0, 14'h26FF, 1'b1, 8'h9D, 1'b1, 16'd10, 16'd7, 16'd4};
      vec[19] = '{1'b0, 14'h3F00, 1'b0, 8'h9D, 1'b0, 16'd10, 16'd7, 16'd4};

      ALE = 1'b0; RD = 1'b1; WR = 1'b1; ad_in = '0; a_hi = '0;
      mirror_vertical = 1'b0; error_clear = 1'b0;
      RST = 1'b1;
      #2 RST = 1'b0;
      cycles(3);
      check("reset ad_oe", 16'(ad_oe), 16'h0);
      check("reset ad_out", 16'(ad_out), 16'h0);
      check("reset protocol_error", 16'(protocol_error), 16'h0);
      check("reset read_count", read_count, 16'h0);
      check("reset write_count", write_count, 16'h0);
      check("reset ro protocol_error", 16'(ro_protocol_error), 16'h0);
      RST = 1'b1;
      cycles(2);

      // Strobe with no latched address.
      RD = 1'b0;
      cycles(4);
      check("idle strobe protocol_error", 16'(protocol_error), 16'h1);
      check("idle strobe ro protocol_error", 16'(ro_protocol_error), 16'h1);
      check("idle strobe ad_oe", 16'(ad_oe), 16'h0);
      RD = 1'b1;
      cycles(4);
      check("idle strobe read_count", read_count, 16'h0);
      error_clear = 1'b1;
      cycles(1);
      error_clear = 1'b0;
      check("error_clear", 16'(protocol_error), 16'h0);

      // Vector table.
      for (int i = 0; i < 20; i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         bus_latch(vec[i].addr, vec[i].mv);
         if (vec[i].wr) begin
            bus_write(vec[i].data);
         end else begin
            bus_read(tag, vec[i].exp_oe, vec[i].data, 1'b1, vec[i].addr[13], ro_tmp);
         end
         check({tag, " read_count"}, read_count, vec[i].rc);
         check({tag, " ro read_count"}, ro_read_count, vec[i].rc);
         check({tag, " write_count"}, write_count, vec[i].wc);
         check({tag, " ro write_count"}, ro_write_count, vec[i].wc_ro);
      end
      exp_rc = 16'd10; exp_wc = 16'd7; exp_wc_ro = 16'd4;

      // Read-only CHR: the write is discarded and the byte read back is unchanged.
      bus_latch(14'h1234, 1'b1);
      bus_read("ro pre", 1'b1, 8'h00, 1'b0, 1'b0, ro_base);
      exp_rc++;
      bus_write(8'h96);
      exp_wc++;
      check("ro write_count", ro_write_count, exp_wc_ro);
      check("rw write_count", write_count, exp_wc);
      bus_read("ro post", 1'b1, 8'h96, 1'b1, 1'b0, ro_tmp);
      exp_rc++;
      check("ro chr unchanged", 16'(ro_tmp), 16'(ro_base));
      check("ro read_count", ro_read_count, exp_rc);

      // ALE rise in the middle of a read aborts it.
      bus_latch(14'h2405, 1'b1);
      RD = 1'b0;
      cycles(5);
      check("abort oe before ALE", 16'(ad_oe), 16'h1);
      ALE = 1'b1;
      cycles(3);
      check("abort oe 2 edges after ALE", 16'(ad_oe), 16'h0);
      RD = 1'b1;
      cycles(3);
      ALE = 1'b0;
      cycles(4);
      check("abort read_count", read_count, exp_rc);
      check("abort protocol_error", 16'(protocol_error), 16'h0);

      // RD and WR low together; a same-cycle clear loses to the set.
      bus_latch(14'h2405, 1'b1);
      ad_in = 8'hFF;
      RD = 1'b0;
      WR = 1'b0;
      cycles(3);
      error_clear = 1'b1;
      cycles(1);
      error_clear = 1'b0;
      check("overlap set beats clear", 16'(protocol_error), 16'h1);
      RD = 1'b1;
      WR = 1'b1;
      cycles(4);
      check("overlap protocol_error", 16'(protocol_error), 16'h1);
      check("overlap ad_oe", 16'(ad_oe), 16'h0);
      check("overlap write_count", write_count, exp_wc);
      check("overlap read_count", read_count, exp_rc);
      error_clear = 1'b1;
      cycles(1);
      error_clear = 1'b0;
      check("overlap cleared", 16'(protocol_error), 16'h0);
      bus_latch(14'h2405, 1'b1);
      bus_read("overlap ram", 1'b1, 8'hA5, 1'b1, 1'b1, ro_tmp);
      exp_rc++;

      // Counter wrap: preset to the top value, one more read wraps it.
      force dut.read_count = 16'hFFFF;
      cycles(1);
      release dut.read_count;
      cycles(1);
      bus_latch(14'h2405, 1'b1);
      bus_read("wrap", 1'b1, 8'hA5, 1'b1, 1'b1, ro_tmp);
      exp_rc++;
      check("wrap read_count", read_count, 16'h0000);
      check("wrap ro read_count", ro_read_count, exp_rc);

      // Reset while driving: outputs clear at once, RAM survives.
      bus_latch(14'h1ABC, 1'b1);
      RD = 1'b0;
      cycles(5);
      check("rst pre ad_oe", 16'(ad_oe), 16'h1);
      #2 RST = 1'b0;
      #1;
      check("rst async ad_oe", 16'(ad_oe), 16'h0);
      check("rst async ro ad_oe", 16'(ro_ad_oe), 16'h0);
      check("rst async ad_out", 16'(ad_out), 16'h0);
      check("rst async read_count", read_count, 16'h0);
      check("rst async write_count", write_count, 16'h0);
      check("rst async ro write_count", ro_write_count, 16'h0);
      RD = 1'b1;
      cycles(3);
      RST = 1'b1;
      cycles(2);
      bus_latch(14'h1ABC, 1'b1);
      bus_read("rst ram kept", 1'b1, 8'h3C, 1'b1, 1'b0, ro_tmp);
      check("rst read_count", read_count, 16'h1);
      check("rst write_count", write_count, 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ppu_vram_responder.md
# ppu_vram_responder

Memory-side responder for the PPU's multiplexed video-memory bus: the device at the far end of ALE / RD / WR / AD. It demultiplexes the address, decodes pattern-table (CHR) and nametable space, and serves reads and writes from internal RAM. It sits on the board side of the PPU, where the cartridge CHR and the console nametable RAM normally sit. All bus pins are asynchronous to the block clock and are synchronised internally.

## Interface
- CHR_WRITABLE, 1, 1 = CHR region is RAM (writes commit); 0 = CHR is read-only and writes are discarded.
- CLK  in  1  block clock, rising edge; at least 4x the PPU bus strobe rate.
- RST  in  1  asynchronous, active-low reset.
- ALE  in  1  address latch enable, active-high.
- RD  in  1  read strobe, active-low.
- WR  in  1  write strobe, active-low.
- ad_in  in  8  multiplexed AD[7:0] as seen on the pins.
- a_hi  in  6  A[13:8], non-multiplexed.
- mirror_vertical  in  1  1 = vertical nametable mirroring, 0 = horizontal; sampled at address latch.
- ad_out  out  8  read data.
- ad_oe  out  1  drive enable for ad_out; the top level builds the tri-state from it.
- protocol_error  out  1  sticky error flag.
- error_clear  in  1  synchronous clear for protocol_error.
- read_count  out  16  completed reads, wraps 0xFFFF->0.
- write_count  out  16  committed writes, wraps 0xFFFF->0.

## Operation
- **Synchronisation.** ALE, RD, WR, ad_in and a_hi each pass through two flops (s1, s2).
  - A history flop (s3) on ALE/RD/WR provides edge detection on s2 vs s3.
  - Data and address use the s2 values, so they are cycle-aligned with the strobes.
- **Address latch.** On the synced ALE falling edge, addr[13:0] = {a_hi_s2, ad_in_s2} from the last ALE-high cycle; mirror_vertical is captured at the same time.
- **Decode.**
  - 0x0000–0x1FFF: CHR RAM, 8 KiB, index addr[12:0].
  - 0x2000–0x3EFF: nametable RAM, 2 KiB. Index is {addr[10], addr[9:0]} when vertical, {addr[11], addr[9:0]} when horizontal.
  - 0x3000–0x3EFF mirrors 0x2000–0x2EFF.
  - 0x3F00–0x3FFF: unmapped. No drive and no commit; counters are not touched.
- **FSM states:** IDLE, ARMED, RD_WAIT, RD_DRIVE, WR_HOLD.
  - IDLE → ARMED on the ALE fall.
  - ARMED → RD_WAIT on the RD fall (RAM read issued).
  - RD_WAIT → RD_DRIVE after 1 cycle (registered RAM data).
  - RD_DRIVE → ARMED on the RD rise; read_count increments, but only if the address is mapped.
  - ARMED → WR_HOLD on the WR fall.
  - In WR_HOLD, ad_in_s2 is captured every cycle.
  - WR_HOLD → ARMED on the WR rise; the last captured byte commits to RAM and write_count increments (mapped and writable only).
  - The address stays latched in ARMED, so repeated strobes without a new ALE reuse it.
  - An ALE rise in any state → IDLE. This aborts an in-flight read (ad_oe drops) or write (no commit).
- **Errors.**
  - RD_s2 and WR_s2 low in the same cycle: set protocol_error, abort the current access with no commit and no count, go to IDLE.
  - A strobe falling while in IDLE (no latched address): set protocol_error and ignore the strobe.
  - error_clear clears the flag; a set in the same cycle wins.
- **Reset (RST low, any time):**
  - State IDLE, ad_oe 0, ad_out 0x00, protocol_error 0, both counters 0.
  - All sync flops go to the inactive level: ALE 0, RD 1, WR 1.
  - RAM contents are not cleared.
  - An access interrupted by reset is dropped silently.

## Timing
- Let t0 be the first CLK edge at which the pin change is sampled by s1; the edge is detected combinationally during t0+1.
- **Read.**
  - RD pin fall at t0: RAM address applied at t0+2, data registered at t0+3, ad_oe = 1 and ad_out valid after t0+3 (3-edge latency).
  - RD pin rise at t1: ad_oe = 0 after t1+2; ad_out holds its value. read_count updates at t1+2.
- **Write.** WR pin rise at t1: RAM write and write_count update at t1+2, using the ad_in value sampled at s1 on edge t1-1.
- **Address latch.** ALE pin fall at t0: addr is valid in ARMED after t0+2.
- **Bus requirements.**
  - Minimum strobe and ALE widths: 3 CLK high or low.
  - Data must be stable for 3 CLK before the WR rise.
  - Shorter pulses may be missed. This is not detected, and behaviour is undefined.

## Test plan
- **Nametable read, vertical mirroring.** Preload NT index 0x405 = 0xA5. mirror_vertical = 1, ALE latch 0x2405, RD pulse 6 CLK → ad_out = 0xA5, ad_oe high from the 3rd edge until 2 edges after the RD rise, read_count = 1. Repeat with mirror_vertical = 0 at address 0x2C05 → same byte.
- **CHR write then read.** ALE 0x1ABC, WR pulse with ad_in = 0x3C → write_count = 1. Read of 0x1ABC returns 0x3C. With CHR_WRITABLE = 0: same write → write_count = 0, read returns the preload value.
- **Mirror and unmapped regions.**
  - Write 0x77 at 0x3123, then read 0x2123 → 0x77.
  - Read 0x3F10 → ad_oe stays 0 throughout, read_count unchanged.
- **Abort and overlap.**
  - ALE rises mid-RD → ad_oe drops within 2 edges of the ALE rise, no count.
  - RD and WR both low for 4 CLK → protocol_error = 1, no RAM change.
  - error_clear pulse → protocol_error = 0.
- **Counter wrap and reset.**
  - Force 65536 reads → read_count = 0.
  - Assert RST during RD_DRIVE → ad_oe = 0 immediately (asynchronous), counters 0, RAM contents retained.
